pipe_skid_stage: RTL
====================

Name: pipe_skid_stage

Overview:
- Parametrised pipeline boundary register, the successor to the fixed-field IF/ID stall/bubble register.
- Carries an opaque DATA_W payload between any two CPU stages.
- Uses a valid/ready handshake with a 2-entry skid buffer, so that in_ready_o is purely registered and no stall path is combinational.
- Flush (bubble) support is kept; an occupancy output is added.

Parameters:
DATA_W, 32, payload width in bits (>=1)
BUBBLE_VAL, 0, value (DATA_W bits) driven on out_data_o and loaded into both entries on reset or flush

Ports:
clk_i  input  1  clock, all logic on posedge
rst_i  input  1  synchronous reset, active-high
flush_i  input  1  bubble request; squashes all held entries
in_valid_i  input  1  upstream has payload
in_ready_o  output  1  stage can accept; registered, equals ~skid_valid
in_data_i  input  DATA_W  upstream payload
out_valid_o  output  1  main entry holds a payload
out_ready_i  input  1  downstream accepts (equivalent to ~D_stall)
out_data_o  output  DATA_W  main entry payload; BUBBLE_VAL when empty
count_o  output  2  occupancy, 0..2

Behaviour:
- State: main {main_valid, main_data} and skid {skid_valid, skid_data}. Occupancy values 0, 1 (main only) and 2 (main+skid) are the only legal states; skid_valid=1 with main_valid=0 never occurs.
- Definitions: acc = in_valid_i & in_ready_o; deq = out_valid_o & out_ready_i.
- Outputs:
  - out_valid_o = main_valid
  - out_data_o = main_data
  - in_ready_o = ~skid_valid
  - count_o = main_valid + skid_valid
  - All outputs are direct register outputs.
- Reset (rst_i=1 at posedge), highest priority:
  - main_valid = skid_valid = 0; both data registers = BUBBLE_VAL.
  - Result: out_valid_o=0, in_ready_o=1, count_o=0, out_data_o=BUBBLE_VAL.
  - Reset asserted mid-transfer discards everything.
- Flush (flush_i=1, rst_i=0):
  - Same register effect as reset.
  - A same-cycle acc payload is dropped, not stored. Upstream sees acceptance, which is correct squash semantics.
  - A same-cycle deq still counts as taken downstream; the entry is not replayed.
- Normal update (no reset, no flush), latency 1 cycle from acc to out_valid_o when the stage is empty:
  - count 0: if acc, main <= in, valid.
  - count 1:
    - deq & acc: main <= in (pass-through, full throughput).
    - deq & ~acc: main_valid <= 0, main_data <= BUBBLE_VAL.
    - ~deq & acc: skid <= in, skid_valid <= 1 (in_ready_o drops next cycle).
    - ~deq & ~acc: hold.
  - count 2 (acc impossible, in_ready_o=0):
    - deq: main <= skid, skid_valid <= 0, skid_data <= BUBBLE_VAL.
    - else: hold.
- Ordering: strict FIFO. No payload is duplicated or lost except by flush or reset.
- Sustained throughput: 1 payload per cycle while out_ready_i=1.
- in_data_i is ignored when in_valid_i=0. Holding entries never change data while ~deq.

Optional Feature:
- Macro PIPE_SKID_STAGE_PERF_EN.
- When defined, two extra outputs are added:
  - stall_cnt_o [31:0]: increments each cycle with out_valid_o & ~out_ready_i.
  - flush_cnt_o [31:0]: increments each cycle flush_i=1 while count_o!=0.
  - Both saturate at 32'hFFFF_FFFF, clear on rst_i, and are unaffected by flush.
- When undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Reset then idle: after rst_i=1 for 1 cycle -> out_valid_o=0, in_ready_o=1, count_o=0, out_data_o=BUBBLE_VAL(0).
- Streaming: in_valid_i=1 with data 0x10,0x11,0x12 on consecutive cycles, out_ready_i=1 -> out_data_o shows 0x10,0x11,0x12 one cycle later, count_o stays 1, in_ready_o stays 1.
- Backpressure fill: out_ready_i=0, push 0xA then 0xB -> count_o=2, in_ready_o=0. A third push of 0xC is not accepted. Raise out_ready_i -> outputs 0xA, 0xB, then 0xC after re-acceptance; no loss.
- Flush with full buffer plus same-cycle input: count_o=2 (0xA,0xB), flush_i=1 with in_valid_i=0 -> next cycle count_o=0, out_data_o=BUBBLE_VAL. Repeat at count_o=1 with acc of 0xD -> 0xD never appears at the output.
- Reset mid-operation: count_o=2, rst_i=1 with in_valid_i=1 and out_ready_i=1 -> count_o=0, out_valid_o=0 next cycle.
- With PIPE_SKID_STAGE_PERF_EN: 5 cycles of out_valid_o=1 & out_ready_i=0 -> stall_cnt_o=5. Then flush at count_o=2 -> flush_cnt_o=1, stall_cnt_o remains 5. Preload near 32'hFFFF_FFFF and confirm saturation.

Source files
------------

// File: rtl/pipe_skid_stage.sv
// -----------------------------------------------------------------------------
// pipe_skid_stage
//
// Parametrised pipeline boundary register with a valid/ready handshake and a
// 2-entry skid buffer (main + skid). in_ready_o comes straight from a flop,
// so no stall path runs combinationally from out_ready_i to in_ready_o.
// Flush squashes every held entry back to BUBBLE_VAL.
//
// Parameters:
//   DATA_W      payload width in bits (>=1)
//   BUBBLE_VAL  value shown on out_data_o when empty; loaded on reset/flush
//
// Ports:
//   clk_i        clock, all logic on posedge
//   rst_i        synchronous reset, active-high
//   flush_i      bubble request, squashes all held entries
//   in_valid_i   upstream has payload
//   in_ready_o   stage can accept (registered, ~skid valid)
//   in_data_i    upstream payload
//   out_valid_o  main entry holds a payload
//   out_ready_i  downstream accepts
//   out_data_o   main entry payload, BUBBLE_VAL when empty
//   count_o      occupancy 0..2
//
// Optional build macro PIPE_SKID_STAGE_PERF_EN adds:
//   stall_cnt_o  cycles with out_valid_o & ~out_ready_i (saturating)
//   flush_cnt_o  cycles with flush_i while occupied (saturating)
// -----------------------------------------------------------------------------
module pipe_skid_stage #(
    parameter int                 DATA_W     = 32,
    parameter logic [DATA_W-1:0]  BUBBLE_VAL = '0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [1:0]        count_o
`ifdef PIPE_SKID_STAGE_PERF_EN
    ,
    output logic [31:0]       stall_cnt_o,
    output logic [31:0]       flush_cnt_o
`endif
);

    logic              main_vld_p0;
    logic [DATA_W-1:0] main_data_p0;
    logic              skid_vld_p0;
    logic [DATA_W-1:0] skid_data_p0;

    logic acc;
    logic deq;

    assign acc = in_valid_i & ~skid_vld_p0;
    assign deq = main_vld_p0 & out_ready_i;

    // ---- boundary register: main + skid entries ----
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            // Same-cycle accept is dropped and same-cycle dequeue is not replayed.
            main_vld_p0  <= 1'b0;
            main_data_p0 <= BUBBLE_VAL;
            skid_vld_p0  <= 1'b0;
            skid_data_p0 <= BUBBLE_VAL;
        end else if (!main_vld_p0) begin
            if (acc) begin
                main_vld_p0  <= 1'b1;
                main_data_p0 <= in_data_i;
            end
        end else if (!skid_vld_p0) begin
            if (deq && acc) begin
                main_data_p0 <= in_data_i;
            end else if (deq) begin
                main_vld_p0  <= 1'b0;
                main_data_p0 <= BUBBLE_VAL;
            end else if (acc) begin
                // Downstream stalled: park the new payload; in_ready_o drops next cycle.
                skid_vld_p0  <= 1'b1;
                skid_data_p0 <= in_data_i;
            end
        end else if (deq) begin
            main_data_p0 <= skid_data_p0;
            skid_vld_p0  <= 1'b0;
            skid_data_p0 <= BUBBLE_VAL;
        end
    end

    assign out_valid_o = main_vld_p0;
    assign out_data_o  = main_data_p0;
    assign in_ready_o  = ~skid_vld_p0;
    // skid is only ever valid while main is valid, so this is main + skid.
    assign count_o     = {skid_vld_p0, main_vld_p0 & ~skid_vld_p0};

`ifdef PIPE_SKID_STAGE_PERF_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
        if (en && (v != 32'hFFFF_FFFF)) begin
            return v + 32'd1;
        end
        return v;
    endfunction

    logic [31:0] stall_cnt_p0;
    logic [31:0] flush_cnt_p0;

    // ---- performance counters (cleared only by reset) ----
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_p0 <= 32'd0;
            flush_cnt_p0 <= 32'd0;
        end else begin
            stall_cnt_p0 <= sat_inc(stall_cnt_p0, main_vld_p0 & ~out_ready_i);
            flush_cnt_p0 <= sat_inc(flush_cnt_p0, flush_i & main_vld_p0);
        end
    end

    assign stall_cnt_o = stall_cnt_p0;
    assign flush_cnt_o = flush_cnt_p0;
`endif

endmodule
